// File: rtl/regwrite_tap.sv
// Register-write tap: snoops the regfile write port, keeps a shadow copy of a
// window of game registers and queues every windowed write in an event FIFO.
module regwrite_tap #(
   parameter int         DEPTH  = 8,
   parameter logic [4:0] REG_LO = 5'd20,
   parameter logic [4:0] REG_HI = 5'd27
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrl_writeEnable,
   input  logic [4:0]  ctrl_writeReg,
   input  logic [31:0] data_writeReg,
   output logic        evt_valid,
   input  logic        evt_ready,
   output logic [4:0]  evt_reg,
   output logic [31:0] evt_data,
   input  logic [2:0]  shadow_sel,
   output logic [31:0] shadow_data,
   output logic [4:0]  fill,
   output logic        overflow,
   output logic [7:0]  drop_count
);

   localparam int WIN = int'(REG_HI) - int'(REG_LO) + 1;
   localparam int PW  = $clog2(DEPTH);

   logic [36:0]   mem [DEPTH];
   logic [PW-1:0] rd_ptr_reg;
   logic [PW-1:0] wr_ptr_reg;
   logic [4:0]    fill_reg;
   logic [36:0]   last_reg;
   logic          overflow_reg;
   logic [7:0]    drop_reg;
   logic [31:0]   shadow_reg [8];

   logic        capture;
   logic        pop;
   logic        push;
   logic        drop;
   logic [4:0]  wr_off;
   logic [36:0] head;

   assign capture = ctrl_writeEnable && (ctrl_writeReg != 5'd0) &&
                    (ctrl_writeReg >= REG_LO) && (ctrl_writeReg <= REG_HI);
   assign pop     = (fill_reg != 5'd0) && evt_ready;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign push    = capture && ((fill_reg != 5'(DEPTH)) || pop);
   assign drop    = capture && !push;
   assign wr_off  = ctrl_writeReg - REG_LO;

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         fill_reg     <= '0;
         last_reg     <= '0;
         overflow_reg <= 1'b0;
         drop_reg     <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
            last_reg   <= mem[rd_ptr_reg];
         end
         case ({push, pop})
            2'b10:   fill_reg <= fill_reg + 5'd1;
            2'b01:   fill_reg <= fill_reg - 5'd1;
            default: fill_reg <= fill_reg;
         endcase
         if (drop) begin
            overflow_reg <= 1'b1;
            if (drop_reg != 8'hFF)
               drop_reg <= drop_reg + 8'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push && !reset)
         mem[wr_ptr_reg] <= {ctrl_writeReg, data_writeReg};
   end

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_shadow
         if (gi < WIN) begin : g_live
            always_ff @(posedge clock) begin
               if (reset)
                  shadow_reg[gi] <= '0;
               else if (capture && (wr_off == 5'(gi)))
                  shadow_reg[gi] <= data_writeReg;
            end
         end else begin : g_unused
            assign shadow_reg[gi] = '0;
         end
      end
   endgenerate

   // An empty FIFO keeps presenting the most recently popped entry.
   assign head        = (fill_reg != 5'd0) ? mem[rd_ptr_reg] : last_reg;
   assign evt_valid   = (fill_reg != 5'd0);
   assign evt_reg     = head[36:32];
   assign evt_data    = head[31:0];
   assign fill        = fill_reg;
   assign overflow    = overflow_reg;
   assign drop_count  = drop_reg;
   assign shadow_data = (int'(shadow_sel) < WIN) ? shadow_reg[shadow_sel] : 32'd0;

endmodule

// File: doc/regwrite_tap.md
# regwrite_tap

Register-write tap for the game datapath. It sits beside the regfile and watches the processor's regfile write port (`ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`). It captures writes that land in a configured window of game registers and provides them to the display/game logic in two forms:
- a shadow copy of each windowed register;
- an ordered event FIFO with a valid/ready handshake.

The processor writes and this block reads, so game state reaches the VGA and audio side without extra dmem traffic.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2..16.
- `REG_LO`, 5'd20: lowest watched register index; must be ≥ 1.
- `REG_HI`, 5'd27: highest watched register index; `REG_HI` ≥ `REG_LO`, window ≤ 8 registers.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `ctrl_writeEnable`  in  1  regfile write enable from the processor.
- `ctrl_writeReg`  in  5  regfile destination index.
- `data_writeReg`  in  32  regfile write data.
- `evt_valid`  out  1  FIFO head is valid.
- `evt_ready`  in  1  consumer accepts the head this cycle.
- `evt_reg`  out  5  register index of the head entry.
- `evt_data`  out  32  data of the head entry.
- `shadow_sel`  in  3  shadow index, equal to register minus `REG_LO`.
- `shadow_data`  out  32  shadow value for `shadow_sel`.
- `fill`  out  5  number of FIFO entries currently held.
- `overflow`  out  1  sticky flag: an event was dropped.
- `drop_count`  out  8  number of dropped events, saturating.

## Operation
- Capture condition: `ctrl_writeEnable` = 1 and `REG_LO` ≤ `ctrl_writeReg` ≤ `REG_HI`. Writes to r0 are never captured.
- Shadow update: on every capture, `shadow[ctrl_writeReg - REG_LO]` ← `data_writeReg`. This happens whether or not the FIFO accepts the event.
- Shadow read is combinational. A `shadow_sel` value ≥ window size returns 32'd0.
- FIFO:
  - First-word fall-through; circular buffer with read and write pointers modulo `DEPTH`.
  - Each entry holds {reg[4:0], data[31:0]}.
  - `evt_valid` = (`fill` ≠ 0).
  - `evt_reg`/`evt_data` always show the head entry; they are don't-care when `evt_valid` = 0 but must hold the last value rather than X.
- Pop: occurs when `evt_valid` && `evt_ready`. When `evt_valid` = 0, `evt_ready` is ignored.
- Push: occurs on capture when `fill` < `DEPTH`, or when `fill` = `DEPTH` and a pop occurs in the same cycle.
- Drop: a capture with no push is dropped.
  - `drop_count` increments and saturates at 255.
  - `overflow` is set to 1 and stays set until reset.
  - The shadow copy is still updated.
- `fill` arithmetic:
  - push only: +1.
  - pop only: −1.
  - both: unchanged.
  - The pointers wrap from `DEPTH`−1 to 0.
- Ordering: events leave in processor write order. Two writes to the same register produce two events.

## Timing
- Reset values (on the cycle after `reset` is sampled high):
  - `evt_valid` = 0, `fill` = 0, pointers = 0.
  - `evt_reg` = 0, `evt_data` = 0.
  - all shadows = 0, so `shadow_data` = 0.
  - `overflow` = 0, `drop_count` = 0.
- Reset has priority over any concurrent capture, pop, or drop; the write in that cycle is lost.
- Capture to `evt_valid` latency: 1 cycle. A write sampled at edge N appears at the head after edge N when the FIFO was empty.
- Capture to `shadow_data` latency: 1 cycle. A same-cycle read returns the old value; there is no bypass.
- Empty FIFO with push and `evt_ready` = 1 in the same cycle: no pop (valid was low); the entry is visible next cycle.
- Full FIFO with push and pop in the same cycle: both happen, `fill` stays at `DEPTH`, and no drop is counted.
- Full FIFO with push and no pop: drop; `fill` stays at `DEPTH`.
- Back-to-back captures on every cycle with `evt_ready` held at 1 sustain one event per cycle with no drops.

## Test plan
- Reset → all outputs 0. Then write r21 = 32'hDEADBEEF → next cycle `evt_valid` = 1, `evt_reg` = 21, `evt_data` = DEADBEEF, `fill` = 1. With `shadow_sel` = 1, `shadow_data` = DEADBEEF.
- Writes to r0, r19, r28, and a write with `ctrl_writeEnable` = 0 → `fill` stays 0, all shadows stay 0.
- `evt_ready` = 0; 10 writes r20 = 1..10 with `DEPTH` = 8 → `fill` = 8, `overflow` = 1, `drop_count` = 2, shadow[0] = 10. Draining yields data 1..8 in order, then `evt_valid` = 0.
- FIFO full with `evt_ready` = 1 and a push in the same cycle → `fill` stays 8, `drop_count` unchanged, new data appears at the tail.
- 300 writes while full with no pops → `drop_count` = 255 and holds; `overflow` = 1. Then assert `reset` in the same cycle as a write → all state is 0 next cycle, and no entry or shadow update from that write.
- Push/pop interleave across 20 events with `DEPTH` = 8 → pointers wrap, order is preserved, `fill` is correct every cycle.
